// File: rtl/systolic_skew_deskew_unit.sv
// Per-lane delay unit that converts row vectors into the diagonal wavefront
// the systolic array consumes (skew), or re-aligns its output rows (deskew).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   enable          global advance enable; 0 freezes every register
//   mode            0 = skew, 1 = deskew; only sampled while idle
//   in_valid        data_in carries a beat
//   in_ready        beat can be taken (low only while draining)
//   data_in         input row, lane i = element i
//   flush           start draining in-flight data (honoured in STREAM only)
//   data_out        delayed lanes
//   out_lane_valid  per-lane valid of data_out
//   busy            state is not IDLE
//   drain_done      one-cycle pulse after the last drain advance
module systolic_skew_deskew_unit #(
    parameter int MATRIX_WIDTH = 14,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
    input  logic                                   mode,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] data_in,
    input  logic                                   flush,
    output logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] data_out,
    output logic [MATRIX_WIDTH-1:0]                out_lane_valid,
    output logic                                   busy,
    output logic                                   drain_done
);

    localparam int CW = $clog2(MATRIX_WIDTH);
    localparam int NS = MATRIX_WIDTH - 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(NS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t         state;
    logic           active_mode;
    logic [CW-1:0]  cnt;

    logic accept;
    logic advance;
    logic mode_eff;

    assign in_ready = (state != DRAIN);
    assign accept   = enable & in_valid & in_ready;
    assign advance  = enable & (accept | (state == DRAIN));
    assign busy     = (state != IDLE);

    // While idle the tap mapping follows the mode input, so the beat that
    // leaves IDLE is routed with the same mode that gets latched with it.
    assign mode_eff = (state == IDLE) ? mode : active_mode;

    // Control FSM. Draining inserts NS zero beats, which flushes every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            active_mode <= 1'b0;
            cnt         <= '0;
            drain_done  <= 1'b0;
        end else if (enable) begin
            drain_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= STREAM;
                        active_mode <= mode;
                    end
                end
                STREAM: begin
                    // A coincident beat is still taken this cycle.
                    if (flush) begin
                        state <= DRAIN;
                        cnt   <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        state      <= IDLE;
                        drain_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_lane
        localparam int DS = i;
        localparam int DD = MATRIX_WIDTH - 1 - i;

        logic [DATA_WIDTH-1:0] sd [NS];
        logic                  sv [NS];

        logic [DATA_WIDTH-1:0] skew_d;
        logic [DATA_WIDTH-1:0] desk_d;
        logic                  skew_v;
        logic                  desk_v;

        // Stage 0 of the array is delay 1; the chain only moves on advances.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < NS; s++) begin
                    sd[s] <= '0;
                    sv[s] <= 1'b0;
                end
            end else if (advance) begin
                sd[0] <= accept ? data_in[i] : '0;
                sv[0] <= accept;
                for (int s = 1; s < NS; s++) begin
                    sd[s] <= sd[s-1];
                    sv[s] <= sv[s-1];
                end
            end
        end

        if (DS == 0) begin : g_skew_comb
            assign skew_d = data_in[i];
            assign skew_v = accept;
        end else begin : g_skew_tap
            assign skew_d = sd[DS-1];
            assign skew_v = sv[DS-1];
        end

        if (DD == 0) begin : g_desk_comb
            assign desk_d = data_in[i];
            assign desk_v = accept;
        end else begin : g_desk_tap
            assign desk_d = sd[DD-1];
            assign desk_v = sv[DD-1];
        end

        assign data_out[i]       = mode_eff ? desk_d : skew_d;
        assign out_lane_valid[i] = mode_eff ? desk_v : skew_v;
    end

endmodule
